// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU data-memory responder: size encodings, FSM states,
// the latched request payload and the alignment-fault helper.
package cpu_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  localparam logic [1:0] ILLEGAL_SIZE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        size;
    logic              is_unsigned;
  } mem_req_t;

  // Illegal size or an access not aligned to its own width.
  function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lane);
    logic f;
    f = 1'b0;
    if (size == ILLEGAL_SIZE) f = 1'b1;
    else if (size == SIZE_HALF && lane[0]) f = 1'b1;
    else if (size == SIZE_WORD && lane != 2'b00) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-mask/replicated data and
// load lane extraction with sign or zero extension.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_lane,
  input  logic              i_unsigned,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rword,
  output logic [3:0]        o_mask_c,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic [DATA_W-1:0] o_rdata_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_mask_c  = '0;
    o_wdata_c = '0;
    o_rdata_c = '0;
    w_half    = i_lane[1] ? i_rword[31:16] : i_rword[15:0];
    case (i_lane)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase

    case (mem_size_e'(i_size))
      SIZE_BYTE: begin
        o_mask_c  = 4'(4'b0001 << i_lane);
        o_wdata_c = {4{i_wdata[7:0]}};
        o_rdata_c = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_mask_c  = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata_c = {2{i_wdata[15:0]}};
        o_rdata_c = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_mask_c  = 4'b1111;
        o_wdata_c = i_wdata;
        o_rdata_c = i_rword;
      end
      default: begin
        o_mask_c  = '0;
        o_wdata_c = '0;
        o_rdata_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory behind a valid/ready request channel with a
// programmable wait and a one-cycle response pulse.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(WAIT_CYCLES - 1);

  mem_state_e        r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  mem_req_t          r_req;
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  mem_req_t          w_req;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rword;
  logic [3:0]        w_mask;
  logic [DATA_W-1:0] w_wlanes;
  logic [DATA_W-1:0] w_rext;

  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && r_ready;

  // In IDLE the live inputs are the request; a zero-wait accept commits on that same edge.
  always_comb begin
    w_req             = r_req;
    if (r_state == IDLE) begin
      w_req.we          = req_we;
      w_req.addr        = req_addr;
      w_req.wdata       = req_wdata;
      w_req.size        = req_size;
      w_req.is_unsigned = req_unsigned;
    end
  end

  assign w_enter_resp = ((r_state == IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_cnt == '0));

  assign w_err   = size_fault(w_req.size, w_req.addr[1:0]) || (w_req.addr >= ADDR_LIMIT);
  assign w_idx   = w_req.addr[IDX_W+1:2];
  assign w_rword = w_err ? '0 : r_mem[w_idx];

  mem_lane_align u_align (
    .i_size     (w_req.size),
    .i_lane     (w_req.addr[1:0]),
    .i_unsigned (w_req.is_unsigned),
    .i_wdata    (w_req.wdata),
    .i_rword    (w_rword),
    .o_mask_c   (w_mask),
    .o_wdata_c  (w_wlanes),
    .o_rdata_c  (w_rext)
  );

  // Memory is deliberately outside reset; a reset on the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (rst && w_enter_resp && w_req.we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_req   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req   <= w_req;
            r_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= RESP;
          else             r_cnt   <= r_cnt - WAIT_W'(1);
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
      if (w_enter_resp) begin
        r_valid <= 1'b1;
        r_err   <= w_err;
        r_rdata <= (w_err || w_req.we) ? '0 : w_rext;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: one responder with one wait cycle, one with none.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid1, req_valid0;
  logic        req_ready1, req_ready0;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid1, resp_valid0;
  logic [31:0] resp_rdata1, resp_rdata0;
  logic        resp_err1, resp_err0;

  logic        sel;
  logic        m_ready, m_valid, m_err;
  logic [31:0] m_rdata;

  int tests_run;
  int tests_failed;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  assign m_ready = sel ? req_ready0  : req_ready1;
  assign m_valid = sel ? resp_valid0 : resp_valid1;
  assign m_rdata = sel ? resp_rdata0 : resp_rdata1;
  assign m_err   = sel ? resp_err0   : resp_err1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request on the selected DUT; inputs are scrambled right after accept.
  task automatic do_req(input logic s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic rdy_after);
    int guard;
    sel = s;
    guard = 0;
    @(negedge clk);
    while (!m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    if (s) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_we = ~we; req_addr = 32'h3; req_wdata = ~wdata; req_size = 2'b11; req_unsigned = ~uns;
    lat = 0;
    rdata = 32'hxxxxxxxx;
    err = 1'bx;
    rdy_after = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy_after = m_ready;
      if (m_valid) begin
        rdata = m_rdata;
        err = m_err;
        break;
      end
    end
    if (lat >= 20) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (req_ready1 !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", req_ready1); end
    tests_run++; if (resp_valid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", resp_valid1); end
    tests_run++; if (resp_rdata1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata1); end
    tests_run++; if (resp_err1 !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", resp_err1); end
    rst = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat; logic ra;
    do_req(1'b0, 1'b1, 32'h0, 32'h12345678, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL store_latency: got %0d expected 2", lat); end
    tests_run++; if (rd !== 32'h0 || er !== 1'b0) begin tests_failed++; $display("FAIL store_resp: got rdata %h err %b expected 00000000 0", rd, er); end
    tests_run++; if (ra !== 1'b0) begin tests_failed++; $display("FAIL ready_in_wait: got %b expected 0", ra); end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL load_latency: got %0d expected 2", lat); end
    tests_run++; if (rd !== 32'h12345678 || er !== 1'b0) begin tests_failed++; $display("FAIL load_word: got rdata %h err %b expected 12345678 0", rd, er); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat; logic ra;
    do_req(1'b0, 1'b1, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    do_req(1'b0, 1'b1, 32'h5, 32'h000000AB, 2'b00, 1'b0, rd, er, lat, ra);
    do_req(1'b0, 1'b0, 32'h5, 32'h0, 2'b00, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'hFFFFFFAB) begin tests_failed++; $display("FAIL load_byte_signed: got %h expected ffffffab", rd); end
    do_req(1'b0, 1'b0, 32'h5, 32'h0, 2'b00, 1'b1, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h000000AB) begin tests_failed++; $display("FAIL load_byte_unsigned: got %h expected 000000ab", rd); end
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 2'b10, 1'b1, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h0000AB00) begin tests_failed++; $display("FAIL load_word_after_byte: got %h expected 0000ab00", rd); end
    do_req(1'b0, 1'b1, 32'h6, 32'hFFFF8123, 2'b01, 1'b0, rd, er, lat, ra);
    do_req(1'b0, 1'b0, 32'h6, 32'h0, 2'b01, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'hFFFF8123) begin tests_failed++; $display("FAIL load_half_signed: got %h expected ffff8123", rd); end
    do_req(1'b0, 1'b0, 32'h6, 32'h0, 2'b01, 1'b1, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h00008123) begin tests_failed++; $display("FAIL load_half_unsigned: got %h expected 00008123", rd); end
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h8123AB00) begin tests_failed++; $display("FAIL load_word_after_half: got %h expected 8123ab00", rd); end
    do_req(1'b0, 1'b1, 32'hFC, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (er !== 1'b0) begin tests_failed++; $display("FAIL last_word_store_err: got %b expected 0", er); end
    do_req(1'b0, 1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL last_word_load: got %h expected cafef00d", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; logic ra;
    logic        e_we   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] e_addr [6] = '{32'h3, 32'h2, 32'h0, 32'h100, 32'h2, 32'h100};
    logic [1:0]  e_size [6] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, e_we[i], e_addr[i], 32'hFFFFFFFF, e_size[i], 1'b0, rd, er, lat, ra);
      tests_run++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin
        tests_failed++;
        $display("FAIL error_case_%0d: got err %b rdata %h lat %0d expected 1 00000000 2", i, er, rd, lat);
      end
    end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL mem_unchanged_0: got %h expected 12345678", rd); end
    do_req(1'b0, 1'b0, 32'h4, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h8123AB00) begin tests_failed++; $display("FAIL mem_unchanged_4: got %h expected 8123ab00", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'hFC};
    logic [31:0] exps  [3] = '{32'h12345678, 32'h8123AB00, 32'hCAFEF00D};
    int acc [3];
    int n_req, n_resp, overlap;
    sel = 1'b0;
    n_req = 0; n_resp = 0; overlap = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (resp_valid1) begin
        if (req_ready1) overlap++;
        if (n_resp < 3) begin
          tests_run++;
          if (resp_rdata1 !== exps[n_resp]) begin
            tests_failed++;
            $display("FAIL b2b_resp_%0d: got %h expected %h", n_resp, resp_rdata1, exps[n_resp]);
          end
        end
        n_resp++;
      end
      if (req_ready1) begin
        if (n_req < 3) begin
          req_we = 1'b0; req_addr = addrs[n_req]; req_size = 2'b10; req_unsigned = 1'b0;
          req_valid1 = 1'b1;
          acc[n_req] = k;
          n_req++;
        end else begin
          req_valid1 = 1'b0;
        end
      end else begin
        req_addr = 32'h3;
        req_size = 2'b11;
      end
    end
    req_valid1 = 1'b0;
    tests_run++; if (n_resp != 3) begin tests_failed++; $display("FAIL b2b_resp_count: got %0d expected 3", n_resp); end
    tests_run++; if (overlap != 0) begin tests_failed++; $display("FAIL b2b_ready_in_resp: got %0d expected 0", overlap); end
    tests_run++; if (n_req != 3 || acc[1] - acc[0] != 3) begin tests_failed++; $display("FAIL b2b_gap_01: got %0d expected 3", acc[1] - acc[0]); end
    tests_run++; if (n_req != 3 || acc[2] - acc[1] != 3) begin tests_failed++; $display("FAIL b2b_gap_12: got %0d expected 3", acc[2] - acc[1]); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; logic ra;
    int hits;
    do_req(1'b0, 1'b1, 32'h8, 32'h0BADF00D, 2'b10, 1'b0, rd, er, lat, ra);
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hDEADBEEF; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid1) hits++;
      if (i == 1) rst = 1'b1;
    end
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL abort_no_resp: got %0d pulses expected 0", hits); end
    tests_run++; if (req_ready1 !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: got %b expected 1", req_ready1); end
    do_req(1'b0, 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h0BADF00D) begin tests_failed++; $display("FAIL abort_no_commit: got %h expected 0badf00d", rd); end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h12345678) begin tests_failed++; $display("FAIL reset_keeps_mem: got %h expected 12345678", rd); end
  endtask

  task automatic test_wait0();
    logic [31:0] rd; logic er; int lat; logic ra;
    do_req(1'b1, 1'b1, 32'h0, 32'h5A5AA5A5, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL w0_store_latency: got %0d expected 1", lat); end
    do_req(1'b1, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat, ra);
    tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL w0_load_latency: got %0d expected 1", lat); end
    tests_run++; if (ra !== 1'b0) begin tests_failed++; $display("FAIL w0_ready_in_resp: got %b expected 0", ra); end
    tests_run++; if (rd !== 32'h5A5AA5A5 || er !== 1'b0) begin tests_failed++; $display("FAIL w0_load_word: got %h err %b expected 5a5aa5a5 0", rd, er); end
    do_req(1'b1, 1'b0, 32'h3, 32'h0, 2'b00, 1'b1, rd, er, lat, ra);
    tests_run++; if (rd !== 32'h0000005A) begin tests_failed++; $display("FAIL w0_load_byte: got %h expected 0000005a", rd); end
    do_req(1'b1, 1'b0, 32'h1, 32'h0, 2'b01, 1'b0, rd, er, lat, ra);
    tests_run++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin tests_failed++; $display("FAIL w0_misaligned: got err %b rdata %h lat %0d expected 1 00000000 1", er, rd, lat); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    sel = 1'b0;
    rst = 1'b0;
    req_valid1 = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = 2'b10; req_unsigned = 1'b0;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
